// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_wb_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned ZERO_REG   = 0;

    // Requester index: 0 = ALU result path, 1 = load return path.
    typedef logic [0:0] req_idx_t;

    // Write-back entry layout at the default widths.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

    // 16-bit saturating increment for the statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with push/pop/flush used as one write-back request queue.
// Flush wins over push and pop; push on full and pop on empty are ignored.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int unsigned Width = DATA_W_DEF + ADDR_W_DEF,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    // Next pointer and occupancy; Depth is a power of two so pointers wrap naturally.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + 1'b1;
            if (pop_ok)  rptr_d = rptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-back arbiter for the register file's single write port.
// Requester 0 = ALU, requester 1 = load return. Each has a FIFO; a round-robin
// arbiter drains them into registered w_addr/w_data/write_en. Writes to x0 are
// accepted but dropped. Optional statistics counters under WB_ARB_STATS_EN.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              write_en,
    output logic              idle
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]       grant0_cnt,
    output logic [15:0]       grant1_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned EntW = ADDR_W + DATA_W;

    logic [CntW-1:0]   cnt0, cnt1;
    logic              full0, full1, empty0, empty1;
    logic              push0, push1, pop0, pop1;
    logic [EntW-1:0]   rd0, rd1;
    logic              gnt_valid;
    req_idx_t          gnt_idx;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    req_idx_t          rr_q, rr_d;
    logic              write_en_q, write_en_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;

    // Ready reflects the count before any same-cycle pop: no push-through when full.
    assign req0_ready = (cnt0 != CntW'(DEPTH)) & ~flush;
    assign req1_ready = (cnt1 != CntW'(DEPTH)) & ~flush;

    // x0 writes complete the handshake but never enter the queue.
    assign push0 = req0_valid & req0_ready & (req0_addr != ADDR_W'(ZERO_REG));
    assign push1 = req1_valid & req1_ready & (req1_addr != ADDR_W'(ZERO_REG));

    wb_fifo #(
        .Width (EntW),
        .Depth (DEPTH)
    ) u_fifo0 (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .flush_i (flush),
        .push_i  (push0),
        .wdata_i ({req0_addr, req0_data}),
        .pop_i   (pop0),
        .rdata_o (rd0),
        .full_o  (full0),
        .empty_o (empty0),
        .count_o (cnt0)
    );

    wb_fifo #(
        .Width (EntW),
        .Depth (DEPTH)
    ) u_fifo1 (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .flush_i (flush),
        .push_i  (push1),
        .wdata_i ({req1_addr, req1_data}),
        .pop_i   (pop1),
        .rdata_o (rd1),
        .full_o  (full1),
        .empty_o (empty1),
        .count_o (cnt1)
    );

    // Round-robin grant among non-empty FIFOs; rr only breaks ties.
    always_comb begin
        gnt_valid = ~empty0 | ~empty1;
        gnt_idx   = req_idx_t'(0);
        if (!empty0 && !empty1) begin
            gnt_idx = rr_q;
        end else if (!empty1) begin
            gnt_idx = req_idx_t'(1);
        end
        pop0 = gnt_valid & ~flush & (gnt_idx == req_idx_t'(0));
        pop1 = gnt_valid & ~flush & (gnt_idx == req_idx_t'(1));
        {gnt_addr, gnt_data} = (gnt_idx == req_idx_t'(1)) ? rd1 : rd0;
    end

    // Next output-register and rr state; address/data hold when nothing is granted.
    always_comb begin
        rr_d       = rr_q;
        write_en_d = 1'b0;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        if (gnt_valid && !flush) begin
            rr_d       = ~gnt_idx;
            write_en_d = 1'b1;
            w_addr_d   = gnt_addr;
            w_data_d   = gnt_data;
        end
    end

    // Registered write port and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q       <= req_idx_t'(0);
            write_en_q <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
        end else begin
            rr_q       <= rr_d;
            write_en_q <= write_en_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
        end
    end

    assign write_en = write_en_q;
    assign w_addr   = w_addr_q;
    assign w_data   = w_data_q;
    assign idle     = (cnt0 == '0) & (cnt1 == '0) & ~write_en_q;

`ifdef WB_ARB_STATS_EN
    logic [15:0] grant0_cnt_q, grant0_cnt_d;
    logic [15:0] grant1_cnt_q, grant1_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating event counters; flush does not clear them.
    always_comb begin
        grant0_cnt_d = grant0_cnt_q;
        grant1_cnt_d = grant1_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (pop0) grant0_cnt_d = sat_inc16(grant0_cnt_q);
        if (pop1) grant1_cnt_d = sat_inc16(grant1_cnt_q);
        if ((req0_valid && !req0_ready) || (req1_valid && !req1_ready)) begin
            stall_cnt_d = sat_inc16(stall_cnt_q);
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant0_cnt_q <= '0;
            grant1_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            grant0_cnt_q <= grant0_cnt_d;
            grant1_cnt_q <= grant1_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign grant0_cnt = grant0_cnt_q;
    assign grant1_cnt = grant1_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule
